// File: rtl/command_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : command_word_sequencer
//  Description : Initialization/operation command-word sequencer for an
//                8259-style interrupt controller. Decodes byte writes
//                (a0 + data) into ICW1..ICW4 during the initialization
//                sequence and OCW1..OCW3 once initialized, and holds the
//                resulting configuration registers.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                  in   system clock, rising edge
//    reset                in   synchronous, active-high reset
//    i_wr_pulse           in   one-cycle write strobe (qualifies a0/din)
//    i_a0                 in   register address bit
//    i_din[7:0]           in   write data
//    o_state[2:0]         out  0 UNINIT,1 WAIT_ICW2,2 WAIT_ICW3,3 WAIT_ICW4,4 READY
//    o_init_done          out  high while in READY
//    o_icw1_wr/o_ocw1_wr/o_ocw2_wr/o_ocw3_wr  out  one-cycle accept strobes
//    o_sngl/o_ic4/o_ltim  out  ICW1 bits 1,0,3
//    o_vector_base[4:0]   out  ICW2[7:3]
//    o_icw3[7:0]          out  cascade configuration byte
//    o_upm/o_aeoi/o_ms/o_buf/o_sfnm  out  ICW4 bits 0..4
//    o_imr[7:0]           out  interrupt mask register
//    o_ocw2_data[7:0]     out  last accepted OCW2 byte
//    o_read_isr           out  read select (0 IRR, 1 ISR)
//    o_special_mask_mode  out  special mask mode enable
//    o_poll_cmd           out  one-cycle poll request
//    o_seq_error          out  one-cycle pulse on any ignored write
// ============================================================================
module command_word_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wr_pulse,
  input  logic       i_a0,
  input  logic [7:0] i_din,
  output logic [2:0] o_state,
  output logic       o_init_done,
  output logic       o_icw1_wr,
  output logic       o_ocw1_wr,
  output logic       o_ocw2_wr,
  output logic       o_ocw3_wr,
  output logic       o_sngl,
  output logic       o_ic4,
  output logic       o_ltim,
  output logic [4:0] o_vector_base,
  output logic [7:0] o_icw3,
  output logic       o_upm,
  output logic       o_aeoi,
  output logic       o_ms,
  output logic       o_buf,
  output logic       o_sfnm,
  output logic [7:0] o_imr,
  output logic [7:0] o_ocw2_data,
  output logic       o_read_isr,
  output logic       o_special_mask_mode,
  output logic       o_poll_cmd,
  output logic       o_seq_error
);

  typedef enum logic [2:0] {
    S_UNINIT    = 3'd0,
    S_WAIT_ICW2 = 3'd1,
    S_WAIT_ICW3 = 3'd2,
    S_WAIT_ICW4 = 3'd3,
    S_READY     = 3'd4
  } state_t;

  localparam logic [7:0] c_IMR_RESET = 8'hFF;

  // registered state
  state_t     r_state;
  logic       r_init_done;
  logic       r_icw1_wr, r_ocw1_wr, r_ocw2_wr, r_ocw3_wr;
  logic       r_sngl, r_ic4, r_ltim;
  logic [4:0] r_vector_base;
  logic [7:0] r_icw3;
  logic       r_upm, r_aeoi, r_ms, r_buf, r_sfnm;
  logic [7:0] r_imr;
  logic [7:0] r_ocw2_data;
  logic       r_read_isr, r_smm;
  logic       r_poll_cmd, r_seq_error;

  // next-state values
  state_t     w_state_nxt;
  logic       w_icw1_wr, w_ocw1_wr, w_ocw2_wr, w_ocw3_wr;
  logic       w_sngl, w_ic4, w_ltim;
  logic [4:0] w_vector_base;
  logic [7:0] w_icw3;
  logic       w_upm, w_aeoi, w_ms, w_buf, w_sfnm;
  logic [7:0] w_imr;
  logic [7:0] w_ocw2_data;
  logic       w_read_isr, w_smm;
  logic       w_poll_cmd, w_seq_error;

  // ICW1 is recognised by data bit 4 on the even address, independent of state
  logic w_is_icw1;
  assign w_is_icw1 = i_wr_pulse && !i_a0 && i_din[4];

  always_comb begin
    w_state_nxt   = r_state;
    w_icw1_wr     = 1'b0;
    w_ocw1_wr     = 1'b0;
    w_ocw2_wr     = 1'b0;
    w_ocw3_wr     = 1'b0;
    w_poll_cmd    = 1'b0;
    w_seq_error   = 1'b0;
    w_sngl        = r_sngl;
    w_ic4         = r_ic4;
    w_ltim        = r_ltim;
    w_vector_base = r_vector_base;
    w_icw3        = r_icw3;
    w_upm         = r_upm;
    w_aeoi        = r_aeoi;
    w_ms          = r_ms;
    w_buf         = r_buf;
    w_sfnm        = r_sfnm;
    w_imr         = r_imr;
    w_ocw2_data   = r_ocw2_data;
    w_read_isr    = r_read_isr;
    w_smm         = r_smm;

    if (w_is_icw1) begin
      // restart: partial configuration from an earlier sequence is discarded
      w_state_nxt = S_WAIT_ICW2;
      w_icw1_wr   = 1'b1;
      w_sngl      = i_din[1];
      w_ic4       = i_din[0];
      w_ltim      = i_din[3];
      w_imr       = c_IMR_RESET;
      w_read_isr  = 1'b0;
      w_smm       = 1'b0;
      w_icw3      = 8'h00;
      w_upm       = 1'b0;
      w_aeoi      = 1'b0;
      w_ms        = 1'b0;
      w_buf       = 1'b0;
      w_sfnm      = 1'b0;
    end else begin
      case (r_state)
        S_UNINIT: begin
          w_seq_error = i_wr_pulse;
        end
        S_WAIT_ICW2: begin
          if (i_wr_pulse) begin
            if (i_a0) begin
              w_vector_base = i_din[7:3];
              if (!r_sngl)    w_state_nxt = S_WAIT_ICW3;
              else if (r_ic4) w_state_nxt = S_WAIT_ICW4;
              else            w_state_nxt = S_READY;
            end else begin
              w_seq_error = 1'b1;
            end
          end
        end
        S_WAIT_ICW3: begin
          if (i_wr_pulse) begin
            if (i_a0) begin
              w_icw3      = i_din;
              w_state_nxt = r_ic4 ? S_WAIT_ICW4 : S_READY;
            end else begin
              w_seq_error = 1'b1;
            end
          end
        end
        S_WAIT_ICW4: begin
          if (i_wr_pulse) begin
            if (i_a0) begin
              w_upm       = i_din[0];
              w_aeoi      = i_din[1];
              w_ms        = i_din[2];
              w_buf       = i_din[3];
              w_sfnm      = i_din[4];
              w_state_nxt = S_READY;
            end else begin
              w_seq_error = 1'b1;
            end
          end
        end
        S_READY: begin
          if (i_wr_pulse) begin
            if (i_a0) begin
              w_imr     = i_din;
              w_ocw1_wr = 1'b1;
            end else if (!i_din[3]) begin
              // din[4] is known low here, so din[3]=0 selects OCW2
              w_ocw2_data = i_din;
              w_ocw2_wr   = 1'b1;
            end else begin
              w_ocw3_wr = 1'b1;
              if (i_din[1]) w_read_isr = i_din[0];
              if (i_din[6]) w_smm      = i_din[5];
              w_poll_cmd = i_din[2];
            end
          end
        end
        default: begin
          // unreachable encodings recover to UNINIT; the write is dropped
          w_state_nxt = S_UNINIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_UNINIT;
      r_init_done   <= 1'b0;
      r_icw1_wr     <= 1'b0;
      r_ocw1_wr     <= 1'b0;
      r_ocw2_wr     <= 1'b0;
      r_ocw3_wr     <= 1'b0;
      r_poll_cmd    <= 1'b0;
      r_seq_error   <= 1'b0;
      r_sngl        <= 1'b0;
      r_ic4         <= 1'b0;
      r_ltim        <= 1'b0;
      r_vector_base <= 5'd0;
      r_icw3        <= 8'h00;
      r_upm         <= 1'b0;
      r_aeoi        <= 1'b0;
      r_ms          <= 1'b0;
      r_buf         <= 1'b0;
      r_sfnm        <= 1'b0;
      r_imr         <= c_IMR_RESET;
      r_ocw2_data   <= 8'h00;
      r_read_isr    <= 1'b0;
      r_smm         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_init_done   <= (w_state_nxt == S_READY);
      r_icw1_wr     <= w_icw1_wr;
      r_ocw1_wr     <= w_ocw1_wr;
      r_ocw2_wr     <= w_ocw2_wr;
      r_ocw3_wr     <= w_ocw3_wr;
      r_poll_cmd    <= w_poll_cmd;
      r_seq_error   <= w_seq_error;
      r_sngl        <= w_sngl;
      r_ic4         <= w_ic4;
      r_ltim        <= w_ltim;
      r_vector_base <= w_vector_base;
      r_icw3        <= w_icw3;
      r_upm         <= w_upm;
      r_aeoi        <= w_aeoi;
      r_ms          <= w_ms;
      r_buf         <= w_buf;
      r_sfnm        <= w_sfnm;
      r_imr         <= w_imr;
      r_ocw2_data   <= w_ocw2_data;
      r_read_isr    <= w_read_isr;
      r_smm         <= w_smm;
    end
  end

  assign o_state             = r_state;
  assign o_init_done         = r_init_done;
  assign o_icw1_wr           = r_icw1_wr;
  assign o_ocw1_wr           = r_ocw1_wr;
  assign o_ocw2_wr           = r_ocw2_wr;
  assign o_ocw3_wr           = r_ocw3_wr;
  assign o_sngl              = r_sngl;
  assign o_ic4               = r_ic4;
  assign o_ltim              = r_ltim;
  assign o_vector_base       = r_vector_base;
  assign o_icw3              = r_icw3;
  assign o_upm               = r_upm;
  assign o_aeoi              = r_aeoi;
  assign o_ms                = r_ms;
  assign o_buf               = r_buf;
  assign o_sfnm              = r_sfnm;
  assign o_imr               = r_imr;
  assign o_ocw2_data         = r_ocw2_data;
  assign o_read_isr          = r_read_isr;
  assign o_special_mask_mode = r_smm;
  assign o_poll_cmd          = r_poll_cmd;
  assign o_seq_error         = r_seq_error;

endmodule
`default_nettype wire

// File: tb/tb_command_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_command_word_sequencer
//  Description : Directed and randomized bench for command_word_sequencer,
//                compared against a behavioural model of the command rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_command_word_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic       a0 = 1'b0;
  logic [7:0] din = 8'h00;

  logic [2:0] state;
  logic       init_done, icw1_wr, ocw1_wr, ocw2_wr, ocw3_wr;
  logic       sngl, ic4, ltim;
  logic [4:0] vector_base;
  logic [7:0] icw3;
  logic       upm, aeoi, ms, bufm, sfnm;
  logic [7:0] imr, ocw2_data;
  logic       read_isr, smm, poll_cmd, seq_error;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  command_word_sequencer dut (
    .clk(clk), .reset(reset), .i_wr_pulse(wr), .i_a0(a0), .i_din(din),
    .o_state(state), .o_init_done(init_done),
    .o_icw1_wr(icw1_wr), .o_ocw1_wr(ocw1_wr), .o_ocw2_wr(ocw2_wr), .o_ocw3_wr(ocw3_wr),
    .o_sngl(sngl), .o_ic4(ic4), .o_ltim(ltim), .o_vector_base(vector_base),
    .o_icw3(icw3), .o_upm(upm), .o_aeoi(aeoi), .o_ms(ms), .o_buf(bufm), .o_sfnm(sfnm),
    .o_imr(imr), .o_ocw2_data(ocw2_data), .o_read_isr(read_isr),
    .o_special_mask_mode(smm), .o_poll_cmd(poll_cmd), .o_seq_error(seq_error)
  );

  // ---------------- behavioural model ----------------
  int         m_state;
  bit         m_sngl, m_ic4, m_ltim;
  bit   [4:0] m_vb;
  bit   [7:0] m_icw3, m_icw4, m_imr, m_ocw2;
  bit         m_risr, m_smm;
  bit         s_icw1, s_ocw1, s_ocw2, s_ocw3, s_poll, s_err;

  task automatic model_reset();
    m_state = 0; m_sngl = 0; m_ic4 = 0; m_ltim = 0; m_vb = 0;
    m_icw3 = 0; m_icw4 = 0; m_imr = 8'hFF; m_ocw2 = 0; m_risr = 0; m_smm = 0;
    {s_icw1, s_ocw1, s_ocw2, s_ocw3, s_poll, s_err} = '0;
  endtask

  // next state after the last ICW that precedes any optional ones
  function automatic int after_icw2();
    if (!m_sngl) return 2;
    return m_ic4 ? 3 : 4;
  endfunction

  task automatic model_write(input bit w, input bit ad, input bit [7:0] d);
    {s_icw1, s_ocw1, s_ocw2, s_ocw3, s_poll, s_err} = '0;
    if (!w) return;
    if (!ad && d[4]) begin
      s_icw1 = 1; m_state = 1;
      m_sngl = d[1]; m_ic4 = d[0]; m_ltim = d[3];
      m_imr = 8'hFF; m_risr = 0; m_smm = 0; m_icw3 = 0; m_icw4 = 0;
    end else if (m_state == 4) begin
      if (ad) begin m_imr = d; s_ocw1 = 1; end
      else if (d[4:3] == 2'b00) begin m_ocw2 = d; s_ocw2 = 1; end
      else begin
        s_ocw3 = 1;
        if (d[1]) m_risr = d[0];
        if (d[6]) m_smm = d[5];
        s_poll = d[2];
      end
    end else if (!ad || m_state == 0) begin
      s_err = 1;
    end else if (m_state == 1) begin
      m_vb = d[7:3]; m_state = after_icw2();
    end else if (m_state == 2) begin
      m_icw3 = d; m_state = m_ic4 ? 3 : 4;
    end else begin
      m_icw4 = {3'b000, d[4:0]}; m_state = 4;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", {5'd0, state}, 8'(m_state));
    chk("init_done", {7'd0, init_done}, {7'd0, m_state == 4});
    chk("strobes", {2'b00, icw1_wr, ocw1_wr, ocw2_wr, ocw3_wr, poll_cmd, seq_error},
        {2'b00, s_icw1, s_ocw1, s_ocw2, s_ocw3, s_poll, s_err});
    chk("icw1_bits", {5'd0, sngl, ic4, ltim}, {5'd0, m_sngl, m_ic4, m_ltim});
    chk("vector_base", {3'd0, vector_base}, {3'd0, m_vb});
    chk("icw3", icw3, m_icw3);
    chk("icw4", {3'd0, sfnm, bufm, ms, aeoi, upm}, m_icw4);
    chk("imr", imr, m_imr);
    chk("ocw2_data", ocw2_data, m_ocw2);
    chk("ocw3_bits", {6'd0, read_isr, smm}, {6'd0, m_risr, m_smm});
  endtask

  // one clock: drive at negedge, sample 1 time unit after the rising edge
  task automatic step(input bit rst, input bit w, input bit ad, input logic [7:0] d);
    @(negedge clk);
    reset = rst; wr = w; a0 = ad; din = d;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_write(w, ad, d);
    check_all();
  endtask

  task automatic wr_step(input bit ad, input logic [7:0] d);
    step(1'b0, 1'b1, ad, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    model_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h77);
    chk("reset_imr", imr, 8'hFF);
    idle();

    // writes in UNINIT are rejected
    wr_step(1'b1, 8'h55);
    chk("uninit_err", {7'd0, seq_error}, 8'h01);
    chk("uninit_imr", imr, 8'hFF);
    idle();

    // single, no ICW4
    wr_step(1'b0, 8'h12);
    chk("s1_state", {5'd0, state}, 8'd1);
    wr_step(1'b1, 8'h40);
    chk("s1_ready", {5'd0, state}, 8'd4);
    chk("s1_vb", {3'd0, vector_base}, 8'h08);
    chk("s1_sngl_ic4", {6'd0, sngl, ic4}, 8'h02);

    // READY operation words
    wr_step(1'b1, 8'hA5);
    chk("ocw1_imr", imr, 8'hA5);
    chk("ocw1_wr", {7'd0, ocw1_wr}, 8'h01);
    idle();
    chk("ocw1_wr_low", {7'd0, ocw1_wr}, 8'h00);
    wr_step(1'b0, 8'h6B);
    chk("ocw3_fields", {5'd0, read_isr, smm, poll_cmd}, 8'h06);
    wr_step(1'b0, 8'h0C);
    chk("ocw3_poll", {5'd0, read_isr, smm, poll_cmd}, 8'h07);
    idle();
    wr_step(1'b0, 8'h20);
    chk("ocw2_data", ocw2_data, 8'h20);

    // cascade with ICW4
    wr_step(1'b0, 8'h11);
    wr_step(1'b1, 8'h20);
    chk("c_state2", {5'd0, state}, 8'd2);
    wr_step(1'b1, 8'h04);
    chk("c_state3", {5'd0, state}, 8'd3);
    wr_step(1'b1, 8'h03);
    chk("c_ready", {5'd0, state}, 8'd4);
    chk("c_icw3", icw3, 8'h04);
    chk("c_aeoi_upm", {6'd0, aeoi, upm}, 8'h03);

    // reset wins over a concurrent write
    wr_step(1'b1, 8'h3C);
    step(1'b1, 1'b1, 1'b1, 8'h00);
    chk("rst_wr_imr", imr, 8'hFF);
    chk("rst_wr_ocw1", {7'd0, ocw1_wr}, 8'h00);
    wr_step(1'b0, 8'h20);
    chk("post_rst_err", {7'd0, seq_error}, 8'h01);

    // OCW2 in WAIT_ICW2 is rejected
    wr_step(1'b0, 8'h12);
    wr_step(1'b0, 8'h20);
    chk("w2_err", {4'd0, seq_error, state}, 8'h09);

    // restart from WAIT_ICW3
    wr_step(1'b0, 8'h11);
    wr_step(1'b1, 8'h20);
    wr_step(1'b0, 8'h13);
    chk("restart", {4'd0, ic4, state}, 8'h09);
    chk("restart_icw3", icw3, 8'h00);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      bit ad;
      logic [7:0] d;
      r  = $urandom_range(0, 99);
      ad = 1'($urandom);
      d  = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin ad = 1'b0; d[4] = 1'b1; end
      else if (!ad && $urandom_range(0, 1) == 0) d[4] = 1'b0;
      if (r < 3) step(1'b1, 1'($urandom), ad, d);
      else step(1'b0, r < 75, ad, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
